// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
// Optional build macro: BCD_SEQ_BLANK_LEAD_EN (leading-zero blanking).
package bcd_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, STORE, DONE} state_t;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  // Number of BCD digits that can always hold an in_w-bit binary value.
  function automatic int nd_of(input int in_w);
    return (in_w + 2) / 3;
  endfunction

  // Edges from accept (counted as edge 1) to the edge that opens the done cycle.
  function automatic int latency_of(input int in_w, input int channels);
    return channels * (in_w + 2) + 1;
  endfunction

endpackage

// File: rtl/bcd_seq_converter_if.sv
// Request/result bundle between the clock logic (master) and the converter (slave).
// Optional build macro: BCD_SEQ_BLANK_LEAD_EN (affects the bcd_bus codes only).
interface bcd_seq_converter_if #(
  parameter int IN_W     = 6,
  parameter int DIGITS   = 2,
  parameter int CHANNELS = 3
) ();

  // start is taken on a rising edge only while busy=0; busy stays high from that
  // edge through the done cycle, and done is a one-cycle pulse with bcd_bus/ovf valid.
  logic                         start;
  logic [CHANNELS*IN_W-1:0]     in_bus;
  logic                         busy;
  logic                         done;
  logic [CHANNELS*DIGITS*4-1:0] bcd_bus;
  logic [CHANNELS-1:0]          ovf;
  bcd_pkg::state_t              dbg_state;

  modport master (
    output start, in_bus,
    input  busy, done, bcd_bus, ovf, dbg_state
  );

  modport slave (
    input  start, in_bus,
    output busy, done, bcd_bus, ovf, dbg_state
  );

endinterface

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every BCD digit >= 5, then shift the
// whole scratch register left by one bit.
module bcd_dabble_step #(
  parameter int ND   = 2,
  parameter int IN_W = 6
) (
  input  logic [ND*4+IN_W-1:0] din,
  output logic [ND*4+IN_W-1:0] dout
);

  logic [ND*4+IN_W-1:0] adj;

  always_comb begin
    adj = din;
    for (int i = 0; i < ND; i++) begin
      if (din[IN_W+i*4 +: 4] >= 4'd5) begin
        adj[IN_W+i*4 +: 4] = din[IN_W+i*4 +: 4] + 4'd3;
      end
    end
    dout = adj << 1;
  end

endmodule

// File: rtl/bcd_seq_converter.sv
// Time-multiplexed double-dabble converter, one bit per clock per channel.
// Optional build macro: BCD_SEQ_BLANK_LEAD_EN blanks leading zero digits with 4'hF.
module bcd_seq_converter
  import bcd_pkg::*;
#(
  parameter int IN_W     = 6,
  parameter int DIGITS   = 2,
  parameter int CHANNELS = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  bcd_seq_converter_if.slave   bus
);

  localparam int ND = nd_of(IN_W);
  localparam int SW = ND*4 + IN_W;
  localparam int MD = (ND > DIGITS) ? ND : DIGITS;
  localparam int XW = MD*4;
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int BW = $clog2(IN_W + 1);
  localparam int OW = CHANNELS*DIGITS*4;

  state_t                   state_q, state_d;
  logic [CHANNELS*IN_W-1:0] in_lat_q, in_lat_d;
  logic [CW-1:0]            chan_q, chan_d;
  logic [BW-1:0]            bitcnt_q, bitcnt_d;
  logic [SW-1:0]            scratch_q, scratch_d, step_out;
  logic [OW-1:0]            shadow_q, shadow_d, bcd_q, bcd_d, disp;
  logic [CHANNELS-1:0]      shadow_ovf_q, shadow_ovf_d, ovf_q, ovf_d;
  logic [XW-1:0]            bcd_ext;
  logic                     ch_ovf;

  bcd_dabble_step #(.ND(ND), .IN_W(IN_W)) u_step (
    .din  (scratch_q),
    .dout (step_out)
  );

  // BCD part of the scratch, zero-extended so DIGITS may exceed ND.
  assign bcd_ext = XW'(scratch_q[SW-1 -: ND*4]);

  always_comb begin
    ch_ovf = 1'b0;
    for (int d = DIGITS; d < ND; d++) begin
      ch_ovf = ch_ovf | (bcd_ext[d*4 +: 4] != 4'd0);
    end
  end

  always_comb begin
    state_d      = state_q;
    in_lat_d     = in_lat_q;
    chan_d       = chan_q;
    bitcnt_d     = bitcnt_q;
    scratch_d    = scratch_q;
    shadow_d     = shadow_q;
    shadow_ovf_d = shadow_ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          in_lat_d = bus.in_bus;
          chan_d   = '0;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        scratch_d = SW'(in_lat_q[int'(chan_q)*IN_W +: IN_W]);
        bitcnt_d  = BW'(IN_W);
        state_d   = SHIFT;
      end
      SHIFT: begin
        scratch_d = step_out;
        bitcnt_d  = bitcnt_q - 1'b1;
        if (bitcnt_q == BW'(1)) state_d = STORE;
      end
      STORE: begin
        for (int d = 0; d < DIGITS; d++) begin
          shadow_d[(int'(chan_q)*DIGITS + d)*4 +: 4] = bcd_ext[d*4 +: 4];
        end
        shadow_ovf_d[chan_q] = ch_ovf;
        if (chan_q == CW'(CHANNELS-1)) begin
          state_d = DONE;
        end else begin
          chan_d  = chan_q + 1'b1;
          state_d = LOAD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    disp = shadow_d;
`ifdef BCD_SEQ_BLANK_LEAD_EN
    for (int k = 0; k < CHANNELS; k++) begin
      logic lead;
      lead = !shadow_ovf_d[k];
      for (int d = DIGITS-1; d >= 1; d--) begin
        if (lead && (disp[(k*DIGITS + d)*4 +: 4] == 4'd0)) begin
          disp[(k*DIGITS + d)*4 +: 4] = BLANK_CODE;
        end else begin
          lead = 1'b0;
        end
      end
    end
`endif
  end

  // Results land on the edge into DONE, so they are visible exactly while done is high.
  always_comb begin
    bcd_d = bcd_q;
    ovf_d = ovf_q;
    if ((state_q == STORE) && (chan_q == CW'(CHANNELS-1))) begin
      bcd_d = disp;
      ovf_d = shadow_ovf_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      in_lat_q     <= '0;
      chan_q       <= '0;
      bitcnt_q     <= '0;
      scratch_q    <= '0;
      shadow_q     <= '0;
      shadow_ovf_q <= '0;
      bcd_q        <= '0;
      ovf_q        <= '0;
    end else begin
      state_q      <= state_d;
      in_lat_q     <= in_lat_d;
      chan_q       <= chan_d;
      bitcnt_q     <= bitcnt_d;
      scratch_q    <= scratch_d;
      shadow_q     <= shadow_d;
      shadow_ovf_q <= shadow_ovf_d;
      bcd_q        <= bcd_d;
      ovf_q        <= ovf_d;
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.bcd_bus   = bcd_q;
  assign bus.ovf       = ovf_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Bench for bcd_seq_converter: default 3x6-bit instance plus a 1x7-bit instance,
// directed vectors feeding expected-result queues checked by done monitors.
module tb_bcd_seq_converter;
  import bcd_pkg::*;

  localparam int IN_W = 6, DIGITS = 2, CHANNELS = 3;
  localparam int OW   = CHANNELS*DIGITS*4;
  localparam int W    = OW + CHANNELS;
  localparam int IN_W2 = 7, DIG2 = 2, CH2 = 1;
  localparam int OW2   = CH2*DIG2*4;
  localparam int W2    = OW2 + CH2;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [W-1:0]  exp_q[$];
  logic [W2-1:0] exp2_q[$];
  int            done_cyc_q[$];

  bcd_seq_converter_if #(.IN_W(IN_W),  .DIGITS(DIGITS), .CHANNELS(CHANNELS)) bus ();
  bcd_seq_converter_if #(.IN_W(IN_W2), .DIGITS(DIG2),   .CHANNELS(CH2))      bus2 ();

  bcd_seq_converter #(.IN_W(IN_W), .DIGITS(DIGITS), .CHANNELS(CHANNELS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  bcd_seq_converter #(.IN_W(IN_W2), .DIGITS(DIG2), .CHANNELS(CH2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  function automatic logic [W-1:0] pack3(input logic [3:0] t0, input logic [3:0] o0,
                                         input logic [3:0] t1, input logic [3:0] o1,
                                         input logic [3:0] t2, input logic [3:0] o2,
                                         input logic [2:0] ov);
    logic [3:0] tt [3];
    tt[0] = t0;
    tt[1] = t1;
    tt[2] = t2;
`ifdef BCD_SEQ_BLANK_LEAD_EN
    for (int k = 0; k < 3; k++) if (!ov[k] && tt[k] == 4'd0) tt[k] = 4'hF;
`endif
    return {ov, tt[2], o2, tt[1], o1, tt[0], o0};
  endfunction

  function automatic logic [W2-1:0] pack1(input logic [3:0] t, input logic [3:0] o,
                                          input logic ov);
    logic [3:0] tt;
    tt = t;
`ifdef BCD_SEQ_BLANK_LEAD_EN
    if (!ov && tt == 4'd0) tt = 4'hF;
`endif
    return {ov, tt, o};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [CHANNELS*IN_W-1:0] v, input logic [W-1:0] e);
    bus.start  = 1'b1;
    bus.in_bus = v;
    exp_q.push_back(e);
    @(posedge clk); #1;
    bus.start  = 1'b0;
  endtask

  task automatic issue2(input logic [IN_W2-1:0] v, input logic [W2-1:0] e);
    bus2.start  = 1'b1;
    bus2.in_bus = v;
    exp2_q.push_back(e);
    @(posedge clk); #1;
    bus2.start  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp2_q.size() != 0 || bus.busy || bus2.busy) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) fail_now("drain_timeout");
  endtask

  // ---------------- monitors / scoreboard ----------------
  logic [W-1:0]  e;
  logic [W-1:0]  last_exp = '0;
  logic [W2-1:0] e2;
  int acc_cyc, acc2_cyc, busy_len;
  bit acc_valid, acc2_valid, prev_busy, prev_done;

  always @(negedge clk) begin
    if (reset) begin
      acc_valid = 1'b0;
      busy_len  = 0;
      prev_busy = 1'b0;
      prev_done = 1'b0;
      last_exp  = '0;
    end else begin
      if (bus.busy) busy_len++;
      else if (prev_busy) begin
        check("busy_len", busy_len, 25);
        busy_len = 0;
      end
      if (bus.done) begin
        check("done_single_cycle", prev_done, 0);
        check("busy_during_done", bus.busy, 1);
        if (exp_q.size() == 0) begin
          fail_now("unexpected_done");
        end else begin
          e = exp_q.pop_front();
          check("bcd_bus", bus.bcd_bus, e[OW-1:0]);
          check("ovf", bus.ovf, e[W-1:OW]);
          last_exp = e;
        end
        if (acc_valid) check("latency", cyc - acc_cyc + 1, 25);
        else fail_now("done_without_accept");
        acc_valid = 1'b0;
        done_cyc_q.push_back(cyc);
      end else begin
        check("bcd_hold", bus.bcd_bus, last_exp[OW-1:0]);
        check("ovf_hold", bus.ovf, last_exp[W-1:OW]);
      end
      if (bus.start && !bus.busy) begin
        acc_valid = 1'b1;
        acc_cyc   = cyc + 1;
      end
      prev_busy = bus.busy;
      prev_done = bus.done;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      acc2_valid = 1'b0;
    end else begin
      if (bus2.done) begin
        if (exp2_q.size() == 0) begin
          fail_now("unexpected_done2");
        end else begin
          e2 = exp2_q.pop_front();
          check("bcd_bus2", bus2.bcd_bus, e2[OW2-1:0]);
          check("ovf2", bus2.ovf, e2[W2-1:OW2]);
        end
        if (acc2_valid) check("latency2", cyc - acc2_cyc + 1, 10);
        else fail_now("done2_without_accept");
        acc2_valid = 1'b0;
      end
      if (bus2.start && !bus2.busy) begin
        acc2_valid = 1'b1;
        acc2_cyc   = cyc + 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  int base;

  initial begin
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.in_bus  = '0;
    bus2.start  = 1'b0;
    bus2.in_bus = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_bcd", bus.bcd_bus, 0);
    check("rst_ovf", bus.ovf, 0);
    check("rst_state", bus.dbg_state, IDLE);

    // sec=59, min=59, hrs=23
    issue({6'd59, 6'd59, 6'd23}, pack3(4'd2, 4'd3, 4'd5, 4'd9, 4'd5, 4'd9, 3'b000));
    drain();
    issue({6'd0, 6'd0, 6'd0}, pack3(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 3'b000));
    drain();
    issue({6'd63, 6'd10, 6'd7}, pack3(4'd0, 4'd7, 4'd1, 4'd0, 4'd6, 4'd3, 3'b000));
    drain();

    // start while busy (mid-run and in DONE) plus in_bus changes are ignored
    issue({6'd45, 6'd30, 6'd12}, pack3(4'd1, 4'd2, 4'd3, 4'd0, 4'd4, 4'd5, 3'b000));
    repeat (2) @(posedge clk);
    #1 bus.start = 1'b1;
    bus.in_bus = {6'd1, 6'd2, 6'd3};
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (21) @(posedge clk);
    #1 bus.start = 1'b1;
    check("done_cycle_for_pulse", bus.done, 1);
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    drain();

    // asynchronous reset mid-conversion
    bus.start  = 1'b1;
    bus.in_bus = {6'd1, 6'd1, 6'd1};
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("async_rst_busy", bus.busy, 0);
    check("async_rst_done", bus.done, 0);
    check("async_rst_bcd", bus.bcd_bus, 0);
    check("async_rst_ovf", bus.ovf, 0);
    check("async_rst_state", bus.dbg_state, IDLE);
    exp_q.delete();
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    issue({6'd11, 6'd10, 6'd9}, pack3(4'd0, 4'd9, 4'd1, 4'd0, 4'd1, 4'd1, 3'b000));
    drain();

    // start held high: re-accept on first idle cycle, values sampled per accept
    base = done_cyc_q.size();
    bus.start  = 1'b1;
    bus.in_bus = {6'd0, 6'd50, 6'd33};
    exp_q.push_back(pack3(4'd3, 4'd3, 4'd5, 4'd0, 4'd0, 4'd0, 3'b000));
    @(posedge clk); #1;
    bus.in_bus = {6'd58, 6'd8, 6'd19};
    exp_q.push_back(pack3(4'd1, 4'd9, 4'd0, 4'd8, 4'd5, 4'd8, 3'b000));
    repeat (26) @(posedge clk);
    #1 bus.in_bus = {6'd1, 6'd40, 6'd60};
    exp_q.push_back(pack3(4'd6, 4'd0, 4'd4, 4'd0, 4'd0, 4'd1, 3'b000));
    repeat (26) @(posedge clk);
    #1 bus.start = 1'b0;
    drain();
    if (done_cyc_q.size() >= base + 3) begin
      check("held_period_1", done_cyc_q[base+1] - done_cyc_q[base], 26);
      check("held_period_2", done_cyc_q[base+2] - done_cyc_q[base+1], 26);
    end else begin
      fail_now("held_done_count");
    end

    // 7-bit single channel: overflow truncation and boundaries
    issue2(7'd127, pack1(4'd2, 4'd7, 1'b1));
    drain();
    issue2(7'd99, pack1(4'd9, 4'd9, 1'b0));
    drain();
    issue2(7'd5, pack1(4'd0, 4'd5, 1'b0));
    drain();
    issue2(7'd100, pack1(4'd0, 4'd0, 1'b1));
    drain();

    repeat (5) @(posedge clk);
    #1;
    check("exp_q_empty", exp_q.size(), 0);
    check("exp2_q_empty", exp2_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
